// File: rtl/ad4008_read.sv
// ad4008_read: AD4008 conversion/readback controller; CNV pulse, conversion wait, then
// clocks DATA_WIDTH bits MSB-first out of SDO with a registered SCLK at clk/2.
module ad4008_read #(
    parameter int DATA_WIDTH  = 16,
    parameter int CONV_CYCLES = 6
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  sdo,
    output logic                  cnv,
    output logic                  sclk,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy
);
    localparam int CW = CONV_CYCLES > 1 ? $clog2(CONV_CYCLES) : 1;
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CONVERT, ACQUIRE, SHIFT} state_t;

    state_t                state_q;
    logic [CW-1:0]         conv_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic                  phase_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cnv_q;
    logic                  sclk_q;
    logic                  valid_q;
    logic                  busy_q;

    assign cnv        = cnv_q;
    assign sclk       = sclk_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            cnv_q      <= 1'b0;
            sclk_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    cnv_q      <= 1'b1;
                    busy_q     <= 1'b1;
                    conv_cnt_q <= CW'(CONV_CYCLES - 1);
                    state_q    <= CONVERT;
                end
                CONVERT: if (conv_cnt_q == '0) begin
                    cnv_q   <= 1'b0;
                    state_q <= ACQUIRE;
                end else begin
                    conv_cnt_q <= conv_cnt_q - 1'b1;
                end
                ACQUIRE: begin
                    bit_cnt_q <= BW'(DATA_WIDTH - 1);
                    phase_q   <= 1'b0;
                    state_q   <= SHIFT;
                end
                SHIFT: if (!phase_q) begin
                    // SDO has been stable since the previous falling SCLK; sample as SCLK rises
                    sclk_q  <= 1'b1;
                    shift_q <= {shift_q[DATA_WIDTH-2:0], sdo};
                    phase_q <= 1'b1;
                end else begin
                    sclk_q <= 1'b0;
                    if (bit_cnt_q == '0) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                        phase_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ad4008_read.sv
// tb_ad4008_read: scoreboard bench for ad4008_read with behavioural AD4008 models
// for the default build and an 18-bit / 3-cycle variant.
module tb_ad4008_read;
    logic clk = 1'b0, aresetn = 1'b1;
    logic start_a = 1'b0, sdo_a = 1'b0, start_b = 1'b0, sdo_b = 1'b0;
    logic cnv_a, sclk_a, valid_a, busy_a, cnv_b, sclk_b, valid_b, busy_b;
    logic [15:0] dout_a;
    logic [17:0] dout_b;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    ad4008_read dut_a (.clk(clk), .aresetn(aresetn), .start(start_a), .sdo(sdo_a), .cnv(cnv_a),
        .sclk(sclk_a), .data_out(dout_a), .data_valid(valid_a), .busy(busy_a));
    ad4008_read #(.DATA_WIDTH(18), .CONV_CYCLES(3)) dut_b (.clk(clk), .aresetn(aresetn),
        .start(start_b), .sdo(sdo_b), .cnv(cnv_b), .sclk(sclk_b), .data_out(dout_b),
        .data_valid(valid_b), .busy(busy_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ADC models: MSB appears when CNV falls, next bit after each SCLK falling edge
    logic [15:0] adc_a[$], sb_a[$], aw_a;
    logic [17:0] adc_b[$], sb_b[$], aw_b;
    logic cpa = 1'b0, spa = 1'b0, cpb = 1'b0, spb = 1'b0;
    always @(posedge clk) begin
        #1;
        if (aresetn && cpa && !cnv_a) begin
            aw_a = 16'h0;
            if (adc_a.size() != 0) aw_a = adc_a.pop_front();
            sdo_a = aw_a[15];
            aw_a = aw_a << 1;
        end else if (spa && !sclk_a) begin
            sdo_a = aw_a[15];
            aw_a = aw_a << 1;
        end
        if (aresetn && cpb && !cnv_b) begin
            aw_b = 18'h0;
            if (adc_b.size() != 0) aw_b = adc_b.pop_front();
            sdo_b = aw_b[17];
            aw_b = aw_b << 1;
        end else if (spb && !sclk_b) begin
            sdo_b = aw_b[17];
            aw_b = aw_b << 1;
        end
        cpa = cnv_a; spa = sclk_a; cpb = cnv_b; spb = sclk_b;
    end

    // Monitors: frame timing is measured from the observed CNV rise
    int cyc = 0, lr_a = 0, pr_a = -1, sr_a = 0, ch_a = 0, rises_a = 0;
    int lr_b = 0, pr_b = -1, sr_b = 0, ch_b = 0;
    logic per_a = 1'b0, per_b = 1'b0, mca = 1'b0, msa = 1'b0, mcb = 1'b0, msb = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!aresetn) begin
            sb_a.delete();
            sb_b.delete();
        end
        if (cnv_a && !mca) begin
            rises_a++;
            if (per_a && pr_a >= 0) chk("period_a", cyc - pr_a, 40);
            pr_a = per_a ? cyc : -1;
            lr_a = cyc; sr_a = 0; ch_a = 0;
        end
        if (cnv_a) ch_a++;
        if (sclk_a && !msa) sr_a++;
        if (sclk_a && cnv_a) chk("sclk_during_cnv_a", 1, 0);
        if (valid_a) begin
            if (sb_a.size() == 0) chk("unexpected_valid_a", 1, 0);
            else begin
                chk("data_a", dout_a, sb_a.pop_front());
                chk("latency_a", cyc - lr_a, 39);
                chk("sclk_pulses_a", sr_a, 16);
                chk("cnv_cycles_a", ch_a, 6);
                chk("busy_at_valid_a", busy_a, 0);
            end
        end
        if (cnv_b && !mcb) begin
            if (per_b && pr_b >= 0) chk("period_b", cyc - pr_b, 41);
            pr_b = per_b ? cyc : -1;
            lr_b = cyc; sr_b = 0; ch_b = 0;
        end
        if (cnv_b) ch_b++;
        if (sclk_b && !msb) sr_b++;
        if (valid_b) begin
            if (sb_b.size() == 0) chk("unexpected_valid_b", 1, 0);
            else begin
                chk("data_b", dout_b, sb_b.pop_front());
                chk("latency_b", cyc - lr_b, 40);
                chk("sclk_pulses_b", sr_b, 18);
                chk("cnv_cycles_b", ch_b, 3);
                chk("busy_at_valid_b", busy_b, 0);
            end
        end
        mca = cnv_a; msa = sclk_a; mcb = cnv_b; msb = sclk_b;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_a(input int max);
        for (int n = 0; n < max && sb_a.size() != 0; n++) tick();
        chk("timeout_a", sb_a.size(), 0);
    endtask

    task automatic wait_b(input int max);
        for (int n = 0; n < max && sb_b.size() != 0; n++) tick();
        chk("timeout_b", sb_b.size(), 0);
    endtask

    task automatic frame_a(input logic [15:0] w);
        adc_a.push_back(w);
        sb_a.push_back(w);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        int viol, r0;
        logic [15:0] w;
        #3 aresetn = 1'b0;
        repeat (2) tick();
        chk("rst_cnv", cnv_a, 0);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_data", dout_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_data_b", dout_b, 0);
        aresetn = 1'b1;
        viol = 0;
        repeat (50) begin
            tick();
            viol += int'(cnv_a | sclk_a | busy_a | valid_a);
        end
        chk("idle50", viol, 0);

        frame_a(16'hA5C3);
        chk("busy_hi", busy_a, 1);
        wait_a(100);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            frame_a(16'($urandom));
            wait_a(100);
        end

        // continuous: start held through three frame starts (edges 0, 40, 80)
        r0 = rises_a;
        per_a = 1'b1;
        foreach (adc_a[i]) adc_a.delete(i);
        adc_a.push_back(16'h0000); adc_a.push_back(16'hFFFF); adc_a.push_back(16'h8001);
        sb_a.push_back(16'h0000); sb_a.push_back(16'hFFFF); sb_a.push_back(16'h8001);
        start_a = 1'b1;
        repeat (81) tick();
        start_a = 1'b0;
        wait_a(100);
        per_a = 1'b0;
        repeat (5) tick();
        chk("cont_frames", rises_a - r0, 3);

        // start pulses inside a frame must not queue a conversion
        r0 = rises_a;
        frame_a(16'($urandom));
        repeat (9) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (19) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_a(100);
        repeat (20) tick();
        chk("ignored_start", rises_a - r0, 1);
        frame_a(16'($urandom));
        wait_a(100);
        chk("next_start", rises_a - r0, 2);

        // reset during the 9th SCLK pulse of a 0x1234 frame
        frame_a(16'h1234);
        repeat (24) tick();
        chk("sclk_pre", sclk_a, 1);
        #1 aresetn = 1'b0;
        #1;
        chk("mid_cnv", cnv_a, 0);
        chk("mid_sclk", sclk_a, 0);
        chk("mid_data", dout_a, 0);
        chk("mid_busy", busy_a, 0);
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (60) tick();
        chk("mid_data_after", dout_a, 0);
        frame_a(16'h5678);
        wait_a(100);

        // 18-bit / 3-cycle variant: single frame, then two back-to-back frames
        adc_b.push_back(18'h2ABCD);
        sb_b.push_back(18'h2ABCD);
        start_b = 1'b1; tick(); start_b = 1'b0;
        wait_b(100);
        per_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            adc_b.push_back({w[1:0], w});
            sb_b.push_back({w[1:0], w});
        end
        start_b = 1'b1;
        repeat (42) tick();
        start_b = 1'b0;
        wait_b(100);
        per_b = 1'b0;
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
